rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the 10-bit computer's register file. It shares the file's single write port between two requesters: A (ALU result) and B (memory load). It uses round-robin arbitration, an optional requester lock for back-to-back multi-register writes, and a bounded lock timeout. Output is registered and drives the register file's per-register write enables directly.

## Interface
- DATA_W, 10, write data width
- ADDR_W, 2, register address width
- LOCK_MAX, 4, max cycles a requester may hold the lock (≥2)

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hold  in  1  freeze: no new grants, state and counter frozen
- a_valid / a_ready  in / out  1 / 1  requester A handshake
- a_lock  in  1  A requests ownership after this transfer
- a_addr / a_data  in  ADDR_W / DATA_W  A write target / value
- b_valid / b_ready  in / out  1 / 1  requester B handshake
- b_lock  in  1  B requests ownership after this transfer
- b_addr / b_data  in  ADDR_W / DATA_W  B write target / value
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  write address (registered)
- rf_wdata  out  DATA_W  write data (registered)
- owner  out  2  00 none, 01 A locked, 10 B locked

## Operation
- Transfer: x_valid && x_ready. At most one transfer per cycle.
- States are IDLE, OWN_A, OWN_B. The rr pointer (0 = A preferred) and the lock counter lock_cnt are also state.
- IDLE:
  - Only one requester valid → that one gets ready. The pointer is set to the other requester.
  - Both valid → the pointer side gets ready. The pointer toggles.
  - A transfer with x_lock=1 → OWN_x, lock_cnt=0.
- OWN_x:
  - Only x can be granted. x_ready = x_valid && !hold. The other requester's ready = 0.
  - x transfer with x_lock=0 → IDLE. Pointer set to the other requester.
  - lock_cnt increments each non-hold cycle, whether or not x is valid.
  - lock_cnt == LOCK_MAX-1 → forced IDLE next cycle. Pointer set to the other requester. A transfer in that cycle is still accepted.
- hold=1: both readies 0. State, pointer and lock_cnt unchanged. Any already-registered write still completes.
- ready is combinational from state, pointer, valids and hold. It never depends on the requester's ready.
- Output register:
  - On transfer: rf_wen=1, rf_waddr/rf_wdata = the granted requester's addr/data.
  - Otherwise rf_wen=0. rf_waddr/rf_wdata hold their last values.
- Reset values: state IDLE, pointer 0, lock_cnt 0, rf_wen 0, rf_waddr 0, rf_wdata 0, owner 00. Both readies are 0 while rst=1.
- Reset mid-lock: ownership is dropped. A write accepted in the reset cycle is discarded.

## Timing
- Grant latency is 0 cycles: ready is valid in the same cycle as valid.
- Write latency is 1 cycle: a transfer at edge N produces rf_wen=1 in cycle N+1. The register file captures it at edge N+1.
- Throughput is one write per cycle, sustained, from either requester or alternating.
- Under sustained dual requests, neither requester waits more than 1 grant in IDLE. With locks, the wait is bounded by LOCK_MAX+1 cycles.
- owner reflects the current state, registered.

## Structure
- Shared package rf_pkg:
  - state enum (IDLE, OWN_A, OWN_B)
  - DATA_W, ADDR_W constants
  - owner encoding constants
- Sub-module rf_wb_outreg: rf_wen/rf_waddr/rf_wdata capture register with synchronous reset. It is built bitwise from the existing 1-bit enable register.
- The arbiter FSM, pointer and lock counter live in the top module.

## Test plan
- Reset, then idle for 5 cycles → rf_wen=0, rf_waddr=0, rf_wdata=0, owner=00, both readies 0 during rst.
- A only: addr=2, data=0x155 → a_ready same cycle. Next cycle rf_wen=1, rf_waddr=2, rf_wdata=0x155.
- A and B valid continuously for 4 cycles (pointer=0) → grant order A,B,A,B. rf_wen high for 4 consecutive cycles.
- A with lock=1 for three transfers, then lock=0, while B valid throughout → b_ready=0 for those 4 cycles. B granted on the next cycle. owner goes 01 → 00.
- A locks with LOCK_MAX=4, then drops valid → forced release after 4 cycles. b_ready asserts in cycle 5.
- Assert hold during a dual request for 2 cycles → no readies and no state change. rf_wen=1 for exactly one cycle if a transfer occurred just before hold.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and constants for the register-file write-back arbiter
// Purpose: FSM state encoding, default bus widths and owner encoding used by
//          rf_wb_arbiter, its interface and its output register.
// Ports:   none (package).
package rf_pkg;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - requester/register-file bus bundle for rf_wb_arbiter
// Purpose: groups both requester handshakes, the hold input and the registered
//          register-file write port into one interface.
// Ports:   master = requester/register-file side, slave = arbiter side.
//          hold, a_*/b_* valid/lock/addr/data in to the arbiter; a_ready,
//          b_ready, rf_wen, rf_waddr, rf_wdata, owner out of the arbiter.
interface rf_wb_arbiter_if #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) ();

    logic              hold;
    logic              a_valid;
    logic              a_ready;
    logic              a_lock;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic              b_lock;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [1:0]        owner;

    modport master (
        output hold,
        output a_valid, a_lock, a_addr, a_data,
        output b_valid, b_lock, b_addr, b_data,
        input  a_ready, b_ready,
        input  rf_wen, rf_waddr, rf_wdata, owner
    );

    modport slave (
        input  hold,
        input  a_valid, a_lock, a_addr, a_data,
        input  b_valid, b_lock, b_addr, b_data,
        output a_ready, b_ready,
        output rf_wen, rf_waddr, rf_wdata, owner
    );

endinterface

// File: rtl/rf_wb_arbiter_outreg.sv
// rtl/rf_wb_arbiter_outreg.sv - registered register-file write port
// Purpose: rf_en_dff is the 1-bit synchronous-reset enable register; rf_wb_outreg
//          builds the rf_wen/rf_waddr/rf_wdata capture register from it bit by bit.
// Ports:   clk, rst (sync, active-high); wr = transfer this cycle; addr/data =
//          granted requester's target/value; wen/waddr/wdata = registered outputs.
module rf_en_dff (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module rf_wb_outreg #(
    parameter int DATA_W = rf_pkg::DATA_W,
    parameter int ADDR_W = rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    // Write enable is a one-cycle pulse: always loaded, so it clears itself.
    rf_en_dff u_wen (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .d   (wr),
        .q   (wen)
    );

    // Address and data only load on a transfer and otherwise keep their last value.
    for (genvar i = 0; i < ADDR_W; i++) begin : g_addr
        rf_en_dff u_bit (
            .clk (clk),
            .rst (rst),
            .en  (wr),
            .d   (addr[i]),
            .q   (waddr[i])
        );
    end

    for (genvar i = 0; i < DATA_W; i++) begin : g_data
        rf_en_dff u_bit (
            .clk (clk),
            .rst (rst),
            .en  (wr),
            .d   (data[i]),
            .q   (wdata[i])
        );
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin write-back arbiter with lock and lock timeout
// Purpose: shares the register file's single write port between requester A
//          (ALU) and B (memory load); optional ownership lock bounded by LOCK_MAX.
// Ports:   clk, rst (sync, active-high); bus = rf_wb_arbiter_if.slave carrying
//          hold, both requester handshakes and the registered rf write port/owner.
module rf_wb_arbiter #(
    parameter int DATA_W   = rf_pkg::DATA_W,
    parameter int ADDR_W   = rf_pkg::ADDR_W,
    parameter int LOCK_MAX = 4
) (
    input  logic           clk,
    input  logic           rst,
    rf_wb_arbiter_if.slave bus
);

    import rf_pkg::*;

    localparam int CNT_W = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    state_t            state;
    logic              ptr;        // 0 = A preferred on a tie, 1 = B preferred
    logic [CNT_W-1:0]  lock_cnt;
    logic [1:0]        owner_q;

    logic              a_ready;
    logic              b_ready;
    logic              a_xfer;
    logic              b_xfer;
    logic              lock_end;

    // Grants depend only on state, pointer, valids, hold and reset.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst && !bus.hold) begin
            case (state)
                IDLE: begin
                    a_ready = bus.a_valid && (!bus.b_valid || !ptr);
                    b_ready = bus.b_valid && (!bus.a_valid ||  ptr);
                end
                OWN_A:   a_ready = bus.a_valid;
                OWN_B:   b_ready = bus.b_valid;
                default: ;
            endcase
        end
    end

    assign a_xfer   = bus.a_valid && a_ready;
    assign b_xfer   = bus.b_valid && b_ready;
    assign lock_end = (lock_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            lock_cnt <= '0;
            owner_q  <= OWNER_NONE;
        end else if (!bus.hold) begin
            case (state)
                IDLE: begin
                    if (a_xfer) begin
                        ptr <= 1'b1;
                        if (bus.a_lock) begin
                            state    <= OWN_A;
                            lock_cnt <= '0;
                            owner_q  <= OWNER_A;
                        end
                    end else if (b_xfer) begin
                        ptr <= 1'b0;
                        if (bus.b_lock) begin
                            state    <= OWN_B;
                            lock_cnt <= '0;
                            owner_q  <= OWNER_B;
                        end
                    end
                end
                OWN_A: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    // Timeout wins over a renewed lock; a transfer this cycle still lands.
                    if (lock_end || (a_xfer && !bus.a_lock)) begin
                        state    <= IDLE;
                        ptr      <= 1'b1;
                        lock_cnt <= '0;
                        owner_q  <= OWNER_NONE;
                    end
                end
                OWN_B: begin
                    lock_cnt <= lock_cnt + 1'b1;
                    if (lock_end || (b_xfer && !bus.b_lock)) begin
                        state    <= IDLE;
                        ptr      <= 1'b0;
                        lock_cnt <= '0;
                        owner_q  <= OWNER_NONE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= '0;
                    owner_q  <= OWNER_NONE;
                end
            endcase
        end
    end

    rf_wb_outreg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_outreg (
        .clk   (clk),
        .rst   (rst),
        .wr    (a_xfer || b_xfer),
        .addr  (a_xfer ? bus.a_addr : bus.b_addr),
        .data  (a_xfer ? bus.a_data : bus.b_data),
        .wen   (bus.rf_wen),
        .waddr (bus.rf_waddr),
        .wdata (bus.rf_wdata)
    );

    assign bus.a_ready = a_ready;
    assign bus.b_ready = b_ready;
    assign bus.owner   = owner_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    rf_wb_arbiter_if #(.DATA_W(10), .ADDR_W(2)) bus ();

    rf_wb_arbiter #(.DATA_W(10), .ADDR_W(2), .LOCK_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic l, input logic [1:0] ad, input logic [9:0] d);
        bus.a_valid = v; bus.a_lock = l; bus.a_addr = ad; bus.a_data = d;
    endtask

    task automatic drive_b(input logic v, input logic l, input logic [1:0] ad, input logic [9:0] d);
        bus.b_valid = v; bus.b_lock = l; bus.b_addr = ad; bus.b_data = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.hold = 1'b0;
        drive_a(1'b1, 1'b0, 2'd1, 10'h001);
        drive_b(1'b1, 1'b0, 2'd2, 10'h002);
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++; if (bus.a_ready !== 1'b0) begin miscompares++; $display("FAIL reset_a_ready got %0b want 0", bus.a_ready); end
            vectors++; if (bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL reset_b_ready got %0b want 0", bus.b_ready); end
        end
        rst = 1'b0;
        drive_a(1'b0, 1'b0, 2'd0, 10'h000);
        drive_b(1'b0, 1'b0, 2'd0, 10'h000);
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++; if (bus.rf_wen !== 1'b0) begin miscompares++; $display("FAIL idle_rf_wen c%0d got %0b want 0", c, bus.rf_wen); end
            vectors++; if (bus.rf_waddr !== 2'd0) begin miscompares++; $display("FAIL idle_rf_waddr c%0d got %0d want 0", c, bus.rf_waddr); end
            vectors++; if (bus.rf_wdata !== 10'h000) begin miscompares++; $display("FAIL idle_rf_wdata c%0d got %h want 000", c, bus.rf_wdata); end
            vectors++; if (bus.owner !== 2'b00) begin miscompares++; $display("FAIL idle_owner c%0d got %b want 00", c, bus.owner); end
        end
    endtask

    task automatic test_a_only();
        drive_a(1'b1, 1'b0, 2'd2, 10'h155);
        #1;
        vectors++; if (bus.a_ready !== 1'b1) begin miscompares++; $display("FAIL a_only_a_ready got %0b want 1", bus.a_ready); end
        vectors++; if (bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL a_only_b_ready got %0b want 0", bus.b_ready); end
        tick();
        drive_a(1'b0, 1'b0, 2'd0, 10'h000);
        vectors++; if (bus.rf_wen !== 1'b1) begin miscompares++; $display("FAIL a_only_rf_wen got %0b want 1", bus.rf_wen); end
        vectors++; if (bus.rf_waddr !== 2'd2) begin miscompares++; $display("FAIL a_only_rf_waddr got %0d want 2", bus.rf_waddr); end
        vectors++; if (bus.rf_wdata !== 10'h155) begin miscompares++; $display("FAIL a_only_rf_wdata got %h want 155", bus.rf_wdata); end
        tick();
        vectors++; if (bus.rf_wen !== 1'b0) begin miscompares++; $display("FAIL a_only_wen_drop got %0b want 0", bus.rf_wen); end
        vectors++; if (bus.rf_wdata !== 10'h155) begin miscompares++; $display("FAIL a_only_wdata_hold got %h want 155", bus.rf_wdata); end
    endtask

    // B alone after an A grant: pointer returns to A.
    task automatic test_b_only();
        drive_b(1'b1, 1'b0, 2'd1, 10'h2AA);
        #1;
        vectors++; if (bus.b_ready !== 1'b1) begin miscompares++; $display("FAIL b_only_b_ready got %0b want 1", bus.b_ready); end
        tick();
        drive_b(1'b0, 1'b0, 2'd0, 10'h000);
        vectors++; if (bus.rf_wen !== 1'b1) begin miscompares++; $display("FAIL b_only_rf_wen got %0b want 1", bus.rf_wen); end
        vectors++; if (bus.rf_waddr !== 2'd1) begin miscompares++; $display("FAIL b_only_rf_waddr got %0d want 1", bus.rf_waddr); end
        vectors++; if (bus.rf_wdata !== 10'h2AA) begin miscompares++; $display("FAIL b_only_rf_wdata got %h want 2aa", bus.rf_wdata); end
        tick();
    endtask

    task automatic test_round_robin();
        logic       exp_a;
        logic [9:0] exp_d;
        logic [1:0] exp_ad;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2) == 0;
            drive_a(1'b1, 1'b0, 2'd0, 10'h100 + 10'(i));
            drive_b(1'b1, 1'b0, 2'd3, 10'h200 + 10'(i));
            #1;
            vectors++; if (bus.a_ready !== exp_a) begin miscompares++; $display("FAIL rr_a_ready i%0d got %0b want %0b", i, bus.a_ready, exp_a); end
            vectors++; if (bus.b_ready !== !exp_a) begin miscompares++; $display("FAIL rr_b_ready i%0d got %0b want %0b", i, bus.b_ready, !exp_a); end
            tick();
            exp_d  = exp_a ? (10'h100 + 10'(i)) : (10'h200 + 10'(i));
            exp_ad = exp_a ? 2'd0 : 2'd3;
            vectors++; if (bus.rf_wen !== 1'b1) begin miscompares++; $display("FAIL rr_rf_wen i%0d got %0b want 1", i, bus.rf_wen); end
            vectors++; if (bus.rf_waddr !== exp_ad) begin miscompares++; $display("FAIL rr_rf_waddr i%0d got %0d want %0d", i, bus.rf_waddr, exp_ad); end
            vectors++; if (bus.rf_wdata !== exp_d) begin miscompares++; $display("FAIL rr_rf_wdata i%0d got %h want %h", i, bus.rf_wdata, exp_d); end
        end
        drive_a(1'b0, 1'b0, 2'd0, 10'h000);
        drive_b(1'b0, 1'b0, 2'd0, 10'h000);
        tick();
        vectors++; if (bus.rf_wen !== 1'b0) begin miscompares++; $display("FAIL rr_rf_wen_end got %0b want 0", bus.rf_wen); end
    endtask

    task automatic test_lock();
        logic [1:0] exp_owner;
        drive_b(1'b1, 1'b0, 2'd3, 10'h3C3);
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, (i < 3), 2'(i), 10'h010 + 10'(i));
            #1;
            vectors++; if (bus.a_ready !== 1'b1) begin miscompares++; $display("FAIL lock_a_ready i%0d got %0b want 1", i, bus.a_ready); end
            vectors++; if (bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL lock_b_ready i%0d got %0b want 0", i, bus.b_ready); end
            tick();
            exp_owner = (i < 3) ? 2'b01 : 2'b00;
            vectors++; if (bus.rf_wdata !== (10'h010 + 10'(i))) begin miscompares++; $display("FAIL lock_rf_wdata i%0d got %h want %h", i, bus.rf_wdata, 10'h010 + 10'(i)); end
            vectors++; if (bus.owner !== exp_owner) begin miscompares++; $display("FAIL lock_owner i%0d got %b want %b", i, bus.owner, exp_owner); end
        end
        // A still valid, but the release pointed at B.
        drive_a(1'b1, 1'b0, 2'd0, 10'h0FF);
        #1;
        vectors++; if (bus.b_ready !== 1'b1) begin miscompares++; $display("FAIL lock_release_b_ready got %0b want 1", bus.b_ready); end
        vectors++; if (bus.a_ready !== 1'b0) begin miscompares++; $display("FAIL lock_release_a_ready got %0b want 0", bus.a_ready); end
        tick();
        drive_a(1'b0, 1'b0, 2'd0, 10'h000);
        drive_b(1'b0, 1'b0, 2'd0, 10'h000);
        vectors++; if (bus.rf_wdata !== 10'h3C3) begin miscompares++; $display("FAIL lock_release_rf_wdata got %h want 3c3", bus.rf_wdata); end
        vectors++; if (bus.rf_waddr !== 2'd3) begin miscompares++; $display("FAIL lock_release_rf_waddr got %0d want 3", bus.rf_waddr); end
        tick();
    endtask

    task automatic test_lock_timeout();
        drive_b(1'b1, 1'b0, 2'd1, 10'h0B5);
        drive_a(1'b1, 1'b1, 2'd2, 10'h0A5);
        #1;
        vectors++; if (bus.a_ready !== 1'b1) begin miscompares++; $display("FAIL to_a_ready got %0b want 1", bus.a_ready); end
        tick();
        drive_a(1'b0, 1'b0, 2'd0, 10'h000);
        for (int c = 1; c <= 4; c++) begin
            #1;
            vectors++; if (bus.owner !== 2'b01) begin miscompares++; $display("FAIL to_owner c%0d got %b want 01", c, bus.owner); end
            vectors++; if (bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL to_b_ready c%0d got %0b want 0", c, bus.b_ready); end
            vectors++; if (bus.rf_wen !== (c == 1)) begin miscompares++; $display("FAIL to_rf_wen c%0d got %0b want %0b", c, bus.rf_wen, (c == 1)); end
            tick();
        end
        #1;
        vectors++; if (bus.owner !== 2'b00) begin miscompares++; $display("FAIL to_owner_c5 got %b want 00", bus.owner); end
        vectors++; if (bus.b_ready !== 1'b1) begin miscompares++; $display("FAIL to_b_ready_c5 got %0b want 1", bus.b_ready); end
        tick();
        drive_b(1'b0, 1'b0, 2'd0, 10'h000);
        vectors++; if (bus.rf_wdata !== 10'h0B5) begin miscompares++; $display("FAIL to_rf_wdata got %h want 0b5", bus.rf_wdata); end
        tick();
    endtask

    task automatic test_hold();
        drive_a(1'b1, 1'b0, 2'd1, 10'h111);
        #1;
        vectors++; if (bus.a_ready !== 1'b1) begin miscompares++; $display("FAIL hold_pre_a_ready got %0b want 1", bus.a_ready); end
        tick();
        vectors++; if (bus.rf_wen !== 1'b1) begin miscompares++; $display("FAIL hold_pending_rf_wen got %0b want 1", bus.rf_wen); end
        bus.hold = 1'b1;
        drive_a(1'b1, 1'b0, 2'd2, 10'h122);
        drive_b(1'b1, 1'b0, 2'd3, 10'h233);
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++; if (bus.a_ready !== 1'b0) begin miscompares++; $display("FAIL hold_a_ready c%0d got %0b want 0", c, bus.a_ready); end
            vectors++; if (bus.b_ready !== 1'b0) begin miscompares++; $display("FAIL hold_b_ready c%0d got %0b want 0", c, bus.b_ready); end
            tick();
            vectors++; if (bus.rf_wen !== 1'b0) begin miscompares++; $display("FAIL hold_rf_wen c%0d got %0b want 0", c, bus.rf_wen); end
        end
        bus.hold = 1'b0;
        #1;
        // Pointer was left at B by the pre-hold A grant and must survive hold.
        vectors++; if (bus.b_ready !== 1'b1) begin miscompares++; $display("FAIL hold_post_b_ready got %0b want 1", bus.b_ready); end
        vectors++; if (bus.a_ready !== 1'b0) begin miscompares++; $display("FAIL hold_post_a_ready got %0b want 0", bus.a_ready); end
        tick();
        drive_a(1'b0, 1'b0, 2'd0, 10'h000);
        drive_b(1'b0, 1'b0, 2'd0, 10'h000);
        vectors++; if (bus.rf_wdata !== 10'h233) begin miscompares++; $display("FAIL hold_post_rf_wdata got %h want 233", bus.rf_wdata); end
        tick();
    endtask

    task automatic test_reset_mid_lock();
        drive_b(1'b1, 1'b0, 2'd0, 10'h0C0);
        drive_a(1'b1, 1'b1, 2'd1, 10'h0D0);
        tick();
        vectors++; if (bus.owner !== 2'b01) begin miscompares++; $display("FAIL rml_owner_locked got %b want 01", bus.owner); end
        rst = 1'b1;
        #1;
        vectors++; if (bus.a_ready !== 1'b0) begin miscompares++; $display("FAIL rml_a_ready got %0b want 0", bus.a_ready); end
        tick();
        rst = 1'b0;
        drive_a(1'b0, 1'b0, 2'd0, 10'h000);
        vectors++; if (bus.owner !== 2'b00) begin miscompares++; $display("FAIL rml_owner got %b want 00", bus.owner); end
        vectors++; if (bus.rf_wen !== 1'b0) begin miscompares++; $display("FAIL rml_rf_wen got %0b want 0", bus.rf_wen); end
        #1;
        vectors++; if (bus.b_ready !== 1'b1) begin miscompares++; $display("FAIL rml_b_ready got %0b want 1", bus.b_ready); end
        tick();
        drive_b(1'b0, 1'b0, 2'd0, 10'h000);
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_a_only();
        test_b_only();
        test_round_robin();
        test_lock();
        test_lock_timeout();
        test_hold();
        test_reset_mid_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
